// File: rtl/alu_share_arbiter_if.sv
// Bundle between the ALU-sharing arbiter, its four requesters and the shared ALU.
// slave = arbiter side; master = requesters plus ALU (the environment).
interface alu_share_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 64
);
    logic [NREQ-1:0]       req;
    logic [3*NREQ-1:0]     op;
    logic [NREQ*WIDTH-1:0] opA;
    logic [NREQ*WIDTH-1:0] opB;
    logic [WIDTH-1:0]      alu_A;
    logic [WIDTH-1:0]      alu_B;
    logic [2:0]            alu_cntrl;
    logic [WIDTH-1:0]      alu_result;
    logic [3:0]            alu_flags;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic [3:0]            flags;

    modport slave (
        input  req, op, opA, opB, alu_result, alu_flags,
        output alu_A, alu_B, alu_cntrl, grant, done, result, flags
    );

    modport master (
        output req, op, opA, opB, alu_result, alu_flags,
        input  alu_A, alu_B, alu_cntrl, grant, done, result, flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin IDLE/EXEC/DONE sequencer sharing one ALU among four requesters.
// Operands are frozen at grant; result/flags are captured on the EXEC->DONE edge.
module alu_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 64
) (
    input logic                clk,
    input logic                reset,
    alu_share_arbiter_if.slave bus
);
    localparam int unsigned PtrW = $clog2(NREQ);
    localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [2:0]        alu_cntrl_q, alu_cntrl_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [3:0]        flags_q, flags_d;

    logic [PtrW-1:0]   win;
    logic [PtrW-1:0]   cand;
    logic              found;

    // First requester at or after ptr_q, wrapping through the pointer width.
    always_comb begin
        win   = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = ptr_q + PtrW'(i);
            if (!found && bus.req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cntrl_d = alu_cntrl_q;
        grant_d     = grant_q;
        done_d      = '0;
        result_d    = result_q;
        flags_d     = flags_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d     = win;
                    alu_a_d     = bus.opA[win*WIDTH +: WIDTH];
                    alu_b_d     = bus.opB[win*WIDTH +: WIDTH];
                    alu_cntrl_d = bus.op[win*3 +: 3];
                    grant_d     = OneHot0 << win;
                    state_d     = StExec;
                end
            end
            StExec: begin
                result_d = bus.alu_result;
                flags_d  = bus.alu_flags;
                done_d   = grant_q;
                state_d  = StDone;
            end
            StDone: begin
                ptr_d   = owner_q + PtrW'(1);
                grant_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            owner_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cntrl_q <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cntrl_q <= alu_cntrl_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.alu_A     = alu_a_q;
    assign bus.alu_B     = alu_b_q;
    assign bus.alu_cntrl = alu_cntrl_q;
    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, transaction-level reference model,
// directed test-plan steps followed by a randomized phase.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    alu_share_arbiter_if #(.NREQ(4), .WIDTH(64)) bus ();

    alu_share_arbiter #(.NREQ(4), .WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {negative, zero, overflow, carry_out, result}.
    function automatic logic [67:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] c);
        logic [64:0] w;
        logic [63:0] r;
        logic        v;
        logic        co;
        w = '0; v = 1'b0; co = 1'b0;
        case (c)
            3'b000: r = b;
            3'b010: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[63:0]; co = w[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[63:0]; co = w[64];
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = a;
        endcase
        return {r[63], (r == 64'd0), v, co, r};
    endfunction

    logic [67:0] alu_out;
    always_comb alu_out = alu_fn(bus.alu_A, bus.alu_B, bus.alu_cntrl);
    assign bus.alu_result = alu_out[63:0];
    assign bus.alu_flags  = alu_out[67:64];

    // Reference model: busy countdown (2 = executing, 1 = reporting, 0 = free).
    int          m_cnt = 0;
    int          m_owner = 0;
    int          m_ptr = 0;
    logic [63:0] m_a = '0, m_b = '0, m_res = '0;
    logic [2:0]  m_c = '0;
    logic [3:0]  m_flg = '0;

    task automatic model_step(input logic rst, input logic [3:0] r);
        logic [67:0] o;
        if (rst) begin
            m_cnt = 0; m_owner = 0; m_ptr = 0;
            m_a = '0; m_b = '0; m_c = '0; m_res = '0; m_flg = '0;
        end else if (m_cnt == 0) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (m_cnt == 0 && r[j]) begin
                    m_owner = j;
                    m_a = bus.opA[64*j +: 64];
                    m_b = bus.opB[64*j +: 64];
                    m_c = bus.op[3*j +: 3];
                    m_cnt = 2;
                end
            end
        end else if (m_cnt == 2) begin
            o = alu_fn(m_a, m_b, m_c);
            m_res = o[63:0];
            m_flg = o[67:64];
            m_cnt = 1;
        end else begin
            m_ptr = (m_owner + 1) % 4;
            m_cnt = 0;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [2:0] c, input logic [63:0] a,
                            input logic [63:0] b);
        bus.op[3*i +: 3]   = c;
        bus.opA[64*i +: 64] = a;
        bus.opB[64*i +: 64] = b;
    endtask

    // One clock: drive inputs, advance model, then compare every output at the negedge.
    task automatic cyc(input logic rst, input logic [3:0] r);
        logic [3:0] eg;
        logic [3:0] ed;
        reset   = rst;
        bus.req = r;
        model_step(rst, r);
        @(negedge clk);
        eg = (m_cnt != 0) ? 4'(1 << m_owner) : 4'b0;
        ed = (m_cnt == 1) ? 4'(1 << m_owner) : 4'b0;
        check("grant", 64'(bus.grant), 64'(eg));
        check("done", 64'(bus.done), 64'(ed));
        check("alu_A", bus.alu_A, m_a);
        check("alu_B", bus.alu_B, m_b);
        check("alu_cntrl", 64'(bus.alu_cntrl), 64'(m_c));
        check("result", bus.result, m_res);
        check("flags", 64'(bus.flags), 64'(m_flg));
        check("grant_onehot0", 64'($onehot0(bus.grant)), 64'd1);
    endtask

    int done_order[$];

    initial begin
        reset = 1'b1;
        bus.req = '0;
        bus.op = '0;
        bus.opA = '0;
        bus.opB = '0;
        @(negedge clk);

        // Reset state
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);
        check("rst_grant", 64'(bus.grant), 64'd0);
        check("rst_result", bus.result, 64'd0);

        // Single add on requester 1
        set_slot(1, 3'b010, 64'd5, 64'd7);
        cyc(1'b0, 4'b0010);
        check("add_grant_c1", 64'(bus.grant), 64'h2);
        check("add_cntrl", 64'(bus.alu_cntrl), 64'h2);
        check("add_done_c1", 64'(bus.done), 64'h0);
        cyc(1'b0, 4'b0000);
        check("add_grant_c2", 64'(bus.grant), 64'h2);
        check("add_done_c2", 64'(bus.done), 64'h2);
        check("add_result", bus.result, 64'd12);
        check("add_flags", 64'(bus.flags), 64'h0);
        cyc(1'b0, 4'b0000);
        check("add_idle_grant", 64'(bus.grant), 64'h0);
        check("add_held_result", bus.result, 64'd12);

        // Round-robin fairness from reset
        cyc(1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) set_slot(i, 3'b010, 64'(i + 1), 64'(10 * i));
        for (int n = 0; n < 12; n++) begin
            cyc(1'b0, 4'b1111);
            for (int i = 0; i < 4; i++) if (bus.done[i]) done_order.push_back(i);
        end
        check("rr_count", 64'(done_order.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < done_order.size()) check("rr_order", 64'(done_order[i]), 64'(i));

        // Priority wrap: ptr is back at 0 after requester 3 completed
        cyc(1'b0, 4'b1001);
        check("wrap_first", 64'(bus.grant), 64'h1);
        cyc(1'b0, 4'b1001);
        cyc(1'b0, 4'b1001);
        cyc(1'b0, 4'b1001);
        check("wrap_second", 64'(bus.grant), 64'h8);
        cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0000);

        // Operand freeze and withdrawal
        set_slot(2, 3'b011, 64'd3, 64'd5);
        cyc(1'b0, 4'b0100);
        check("frz_grant", 64'(bus.grant), 64'h4);
        bus.opB[128 +: 64] = 64'd100;
        cyc(1'b0, 4'b0000);
        check("frz_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("frz_neg", 64'(bus.flags[3]), 64'd1);
        check("frz_zero", 64'(bus.flags[2]), 64'd0);
        check("frz_done", 64'(bus.done), 64'h4);
        cyc(1'b0, 4'b0000);

        // Zero flag
        set_slot(0, 3'b110, 64'hDEAD, 64'hDEAD);
        cyc(1'b0, 4'b0001);
        cyc(1'b0, 4'b0000);
        check("zero_result", bus.result, 64'd0);
        check("zero_flag", 64'(bus.flags[2]), 64'd1);
        cyc(1'b0, 4'b0000);

        // Reset mid-operation
        set_slot(3, 3'b101, 64'hF0, 64'h0F);
        cyc(1'b0, 4'b1000);
        check("mid_grant", 64'(bus.grant), 64'h8);
        cyc(1'b1, 4'b1000);
        check("mid_done", 64'(bus.done), 64'h0);
        check("mid_grant0", 64'(bus.grant), 64'h0);
        check("mid_alu_A", bus.alu_A, 64'd0);
        check("mid_result", bus.result, 64'd0);
        cyc(1'b0, 4'b0110);
        check("mid_regrant", 64'(bus.grant), 64'h2);
        cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0000);

        // Randomized traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            logic [3:0] r;
            for (int i = 0; i < 4; i++)
                set_slot(i, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            cyc(($urandom_range(0, 24) == 0), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
